// File: rtl/agc_serial_pkg.sv
// Shared types and constants for the AGC serial input path: frame bytes,
// parser/receiver state encodings and the input-word ID map.
package agc_serial_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         NUM_WORDS = 5;
  localparam int         WORD_W    = 15;

  typedef enum logic [2:0] {
    HUNT,
    GOT_SYNC,
    GOT_ID,
    GOT_HI,
    GOT_LO
  } frame_state_t;

  typedef enum logic [2:0] {
    VERB         = 3'd0,
    NOUN         = 3'd1,
    MISSION_TIME = 3'd2,
    APOGEE       = 3'd3,
    PERIGEE      = 3'd4
  } word_id_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  function automatic logic [7:0] frame_checksum(input logic [7:0] id,
                                                input logic [7:0] hi,
                                                input logic [7:0] lo);
    return id ^ hi ^ lo;
  endfunction

  function automatic logic id_in_range(input logic [7:0] id);
    return id < 8'(NUM_WORDS);
  endfunction

endpackage

// File: rtl/agc_serial_input_uart_rx.sv
// 8N1 UART byte receiver: 2-flop synchronizer, mid-bit sampling, stop-bit
// check. Emits a one-cycle byte strobe or a framing-error strobe.
module uart_rx
  import agc_serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       serial_rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);

  logic             r_rxMeta;
  logic             r_rxSync;
  logic             r_rxPrev;
  rx_state_t        r_state;
  rx_state_t        w_nextState;
  logic [CNT_W-1:0] r_baudCnt;
  logic [2:0]       r_bitIdx;
  logic [7:0]       r_shift;
  logic             w_startEdge;
  logic             w_baudDone;

  // Synchronizer flops reset high so a reset never looks like a start edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rxMeta <= 1'b1;
      r_rxSync <= 1'b1;
      r_rxPrev <= 1'b1;
    end else begin
      r_rxMeta <= serial_rx;
      r_rxSync <= r_rxMeta;
      r_rxPrev <= r_rxSync;
    end
  end

  assign w_startEdge = r_rxPrev & ~r_rxSync;
  assign w_baudDone  = (r_state == RX_START) ? (r_baudCnt == HALF_BIT)
                                             : (r_baudCnt == FULL_BIT);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= RX_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      RX_IDLE:  if (w_startEdge) w_nextState = RX_START;
      RX_START: if (w_baudDone) w_nextState = r_rxSync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_baudDone && r_bitIdx == 3'd7) w_nextState = RX_STOP;
      RX_STOP:  if (w_baudDone) w_nextState = RX_IDLE;
      default:  w_nextState = RX_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_baudCnt <= '0;
      r_bitIdx  <= '0;
      r_shift   <= '0;
    end else begin
      if (r_state == RX_IDLE || w_baudDone) begin
        r_baudCnt <= '0;
      end else begin
        r_baudCnt <= r_baudCnt + 1'b1;
      end
      // LSB arrives first, so bits enter at the top and shift down.
      if (r_state == RX_IDLE) begin
        r_bitIdx <= '0;
      end else if (r_state == RX_DATA && w_baudDone) begin
        r_shift  <= {r_rxSync, r_shift[7:1]};
        r_bitIdx <= r_bitIdx + 1'b1;
      end
    end
  end

  always_comb begin
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    if (r_state == RX_STOP && w_baudDone) begin
      byte_valid = r_rxSync;
      frame_err  = ~r_rxSync;
    end
  end

  assign byte_data = r_shift;

endmodule

// File: rtl/agc_serial_input.sv
// Ground-support serial front end: parses SYNC/ID/HI/LO/CHK frames from the
// UART and holds the five 15-bit input words for the AGC IO register file.
module agc_serial_input
  import agc_serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int TIMEOUT_CLKS = 20 * CLKS_PER_BIT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        serial_rx,
  output logic [14:0] DSKY_VERB_data,
  output logic [14:0] DSKY_NOUN_data,
  output logic [14:0] AXI_MISSION_TIME_data,
  output logic [14:0] AXI_APOGEE_data,
  output logic [14:0] AXI_PERIGEE_data,
  output logic        update_valid,
  output logic [2:0]  update_sel,
  output logic [7:0]  frame_errors
);

  localparam int            TO_W         = $clog2(TIMEOUT_CLKS);
  localparam logic [TO_W-1:0] TIMEOUT_LAST = TO_W'(TIMEOUT_CLKS - 1);

  logic              w_byteValid;
  logic [7:0]        w_byteData;
  logic              w_frameErr;
  frame_state_t      r_state;
  frame_state_t      w_nextState;
  logic [2:0]        r_id;
  logic [6:0]        r_hi;
  logic [7:0]        r_lo;
  logic [7:0]        w_expectChk;
  logic [TO_W-1:0]   r_idleCnt;
  logic [WORD_W-1:0] r_words [NUM_WORDS];
  logic              r_updateValid;
  logic [2:0]        r_updateSel;
  logic [7:0]        r_frameErrors;
  logic              w_protoErr;
  logic              w_commit;
  logic              w_timeout;
  logic              w_anyErr;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clock      (clock),
    .reset      (reset),
    .serial_rx  (serial_rx),
    .byte_valid (w_byteValid),
    .byte_data  (w_byteData),
    .frame_err  (w_frameErr)
  );

  assign w_expectChk = frame_checksum({5'b0, r_id}, {1'b0, r_hi}, r_lo);
  assign w_timeout   = (r_state != HUNT) && !w_byteValid && (r_idleCnt == TIMEOUT_LAST);
  // Simultaneous error sources still count as a single event.
  assign w_anyErr    = w_frameErr | w_protoErr | w_timeout;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= HUNT;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    if (w_frameErr || w_timeout) begin
      w_nextState = HUNT;
    end else if (w_byteValid) begin
      case (r_state)
        HUNT:     if (w_byteData == SYNC_BYTE) w_nextState = GOT_SYNC;
        GOT_SYNC: w_nextState = id_in_range(w_byteData) ? GOT_ID : HUNT;
        GOT_ID:   w_nextState = w_byteData[7] ? HUNT : GOT_HI;
        GOT_HI:   w_nextState = GOT_LO;
        GOT_LO:   w_nextState = HUNT;
        default:  w_nextState = HUNT;
      endcase
    end
  end

  always_comb begin
    w_protoErr = 1'b0;
    w_commit   = 1'b0;
    if (w_byteValid) begin
      case (r_state)
        GOT_SYNC: w_protoErr = !id_in_range(w_byteData);
        GOT_ID:   w_protoErr = w_byteData[7];
        GOT_LO: begin
          w_commit   = (w_byteData == w_expectChk);
          w_protoErr = (w_byteData != w_expectChk);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_id <= '0;
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_byteValid) begin
      case (r_state)
        GOT_SYNC: r_id <= w_byteData[2:0];
        GOT_ID:   r_hi <= w_byteData[6:0];
        GOT_HI:   r_lo <= w_byteData;
        default: ;
      endcase
    end
  end

  // Inter-byte watchdog: only runs while a frame is partially received.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_idleCnt <= '0;
    end else if (r_state == HUNT || w_byteValid || w_timeout) begin
      r_idleCnt <= '0;
    end else begin
      r_idleCnt <= r_idleCnt + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        r_words[i] <= '0;
      end
      r_updateValid <= 1'b0;
      r_updateSel   <= '0;
    end else begin
      r_updateValid <= w_commit;
      r_updateSel   <= w_commit ? r_id : 3'd0;
      for (int i = 0; i < NUM_WORDS; i++) begin
        if (w_commit && r_id == 3'(i)) begin
          r_words[i] <= {r_hi, r_lo};
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_frameErrors <= '0;
    end else if (w_anyErr && r_frameErrors != 8'hFF) begin
      r_frameErrors <= r_frameErrors + 1'b1;
    end
  end

  assign DSKY_VERB_data        = r_words[int'(VERB)];
  assign DSKY_NOUN_data        = r_words[int'(NOUN)];
  assign AXI_MISSION_TIME_data = r_words[int'(MISSION_TIME)];
  assign AXI_APOGEE_data       = r_words[int'(APOGEE)];
  assign AXI_PERIGEE_data      = r_words[int'(PERIGEE)];
  assign update_valid          = r_updateValid;
  assign update_sel            = r_updateSel;
  assign frame_errors          = r_frameErrors;

endmodule
